alu_issue_slice: RTL and testbench

// - One out-of-order ALU execution slice: single-entry reservation station (RS),

---
 rtl/alu_issue_slice_if.sv | 34 +++
 rtl/alu_issue_slice.sv | 149 ++++++++++++++
 tb/tb_alu_issue_slice.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_slice_if.sv
// Dispatch-side and status signals of one ALU issue slice (the shared tri-state CDB stays on plain inout ports).
// master = dispatcher/arbiter side, slave = the slice.
interface alu_issue_slice_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 32
);
    logic                 enable;
    logic [TAG_WIDTH-1:0] q1_in;
    logic [TAG_WIDTH-1:0] q2_in;
    logic [XLEN-1:0]      v1_in;
    logic [XLEN-1:0]      v2_in;
    logic [2:0]           alu_op_in;
    logic                 sign_in;
    logic [TAG_WIDTH-1:0] rob_tag_in;
    logic                 cdb_valid;
    logic                 cdb_permit;
    logic                 busy;
    logic                 ready_to_execute;
    logic                 fu_accept;
    logic                 buf_not_empty;
    logic                 buf_full;

    modport master (
        output enable, q1_in, q2_in, v1_in, v2_in, alu_op_in, sign_in, rob_tag_in,
        output cdb_valid, cdb_permit,
        input  busy, ready_to_execute, fu_accept, buf_not_empty, buf_full
    );

    modport slave (
        input  enable, q1_in, q2_in, v1_in, v2_in, alu_op_in, sign_in, rob_tag_in,
        input  cdb_valid, cdb_permit,
        output busy, ready_to_execute, fu_accept, buf_not_empty, buf_full
    );
endinterface

// File: rtl/alu_issue_slice.sv
// One OoO ALU slice: single-entry RS, combinational RV32I ALU, result FIFO onto a tri-state CDB.
// Latency: issue->accept 1 cycle once operands present; result drives CDB combinationally under permit.
// Backpressure: fu_accept held off while the result FIFO is full. Optional ISSUE_CDB_BYPASS_EN.
module alu_issue_slice #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 32,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_issue_slice_if.slave     io,
    inout  wire  [TAG_WIDTH-1:0] cdb_rob_tag,
    inout  wire  [XLEN-1:0]      cdb_data
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int SH_W  = $clog2(XLEN);

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } res_t;

    logic [TAG_WIDTH-1:0] rs_q1, rs_q2, rs_tag;
    logic [XLEN-1:0]      rs_v1, rs_v2;
    logic [2:0]           rs_op;
    logic                 rs_sign;
    logic                 busy, dispatched;

    res_t                 buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;

    logic                 ready, accept, pop, free_rs, full;
    logic                 cap1, cap2, byp1, byp2;
    logic [XLEN-1:0]      alu_res;
    res_t                 head;

    assign ready   = busy && (rs_q1 == '0) && (rs_q2 == '0) && !dispatched;
    assign full    = (count == (PTR_W+1)'(BUF_DEPTH));
    assign accept  = ready && !full;
    assign pop     = io.cdb_permit && (count != '0);
    assign free_rs = busy && io.cdb_valid && (cdb_rob_tag == rs_tag);
    assign cap1    = busy && io.cdb_valid && (rs_q1 != '0) && (cdb_rob_tag == rs_q1);
    assign cap2    = busy && io.cdb_valid && (rs_q2 != '0) && (cdb_rob_tag == rs_q2);

`ifdef ISSUE_CDB_BYPASS_EN
    assign byp1 = io.cdb_valid && (io.q1_in != '0) && (cdb_rob_tag == io.q1_in);
    assign byp2 = io.cdb_valid && (io.q2_in != '0) && (cdb_rob_tag == io.q2_in);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign io.busy             = busy;
    assign io.ready_to_execute = ready;
    assign io.fu_accept        = accept;
    assign io.buf_not_empty    = (count != '0);
    assign io.buf_full         = full;

    // Arithmetic shift kept in its own branch so the signed context is not lost to a ?: mix.
    always_comb begin
        alu_res = '0;
        case (rs_op)
            3'b000: alu_res = rs_sign ? (rs_v1 - rs_v2) : (rs_v1 + rs_v2);
            3'b001: alu_res = rs_v1 << rs_v2[SH_W-1:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs_v1) < $signed(rs_v2))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (rs_v1 < rs_v2)};
            3'b100: alu_res = rs_v1 ^ rs_v2;
            3'b101: begin
                if (rs_sign) alu_res = $signed(rs_v1) >>> rs_v2[SH_W-1:0];
                else         alu_res = rs_v1 >> rs_v2[SH_W-1:0];
            end
            3'b110: alu_res = rs_v1 | rs_v2;
            3'b111: alu_res = rs_v1 & rs_v2;
            default: alu_res = '0;
        endcase
    end

    // Free wins over capture; enable is ignored while the entry is occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_q1      <= '0;
            rs_q2      <= '0;
            rs_v1      <= '0;
            rs_v2      <= '0;
            rs_op      <= '0;
            rs_sign    <= 1'b0;
            rs_tag     <= '0;
            busy       <= 1'b0;
            dispatched <= 1'b0;
        end else if (free_rs) begin
            rs_q1      <= '0;
            rs_q2      <= '0;
            rs_v1      <= '0;
            rs_v2      <= '0;
            rs_op      <= '0;
            rs_sign    <= 1'b0;
            rs_tag     <= '0;
            busy       <= 1'b0;
            dispatched <= 1'b0;
        end else if (!busy) begin
            if (io.enable) begin
                rs_q1      <= byp1 ? '0 : io.q1_in;
                rs_q2      <= byp2 ? '0 : io.q2_in;
                rs_v1      <= byp1 ? cdb_data : io.v1_in;
                rs_v2      <= byp2 ? cdb_data : io.v2_in;
                rs_op      <= io.alu_op_in;
                rs_sign    <= io.sign_in;
                rs_tag     <= io.rob_tag_in;
                busy       <= 1'b1;
                dispatched <= 1'b0;
            end
        end else begin
            if (cap1) begin
                rs_v1 <= cdb_data;
                rs_q1 <= '0;
            end
            if (cap2) begin
                rs_v2 <= cdb_data;
                rs_q2 <= '0;
            end
            if (accept) dispatched <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buf_mem[wr_ptr] <= '{tag: rs_tag, data: alu_res};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head        = buf_mem[rd_ptr];
    assign cdb_rob_tag = pop ? head.tag  : {TAG_WIDTH{1'bz}};
    assign cdb_data    = pop ? head.data : {XLEN{1'bz}};
endmodule

// File: tb/tb_alu_issue_slice.sv
// Self-checking bench for alu_issue_slice: directed scenarios plus randomized ALU ops
// against a behavioural reference; the bench plays dispatcher, CDB arbiter and other CDB producers.
module tb_alu_issue_slice;
    localparam int XLEN  = 32;
    localparam int TW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_slice_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) io();

    logic            tb_drv;
    logic [TW-1:0]   tb_tag;
    logic [XLEN-1:0] tb_dat;
    wire  [TW-1:0]   cdb_rob_tag;
    wire  [XLEN-1:0] cdb_data;
    assign cdb_rob_tag = tb_drv ? tb_tag : {TW{1'bz}};
    assign cdb_data    = tb_drv ? tb_dat : {XLEN{1'bz}};

    alu_issue_slice #(.XLEN(XLEN), .TAG_WIDTH(TW), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .io(io), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TW-1:0]   tag;
        logic [XLEN-1:0] data;
    } res_t;
    res_t exp_q[$];

    // Reference ALU written from the instruction semantics, not the RTL's structure.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic sg,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0: return sg ? a + (~b + 32'd1) : a + b;
            3'd1: return a << sh;
            3'd2: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            3'd3: return {31'b0, (a < b)};
            3'd4: return a ^ b;
            3'd5: return (a >> sh) | ((sg && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] q1, input logic [31:0] q2, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [2:0] op, input logic sg, input logic [31:0] tag);
        io.enable = 1'b1; io.q1_in = q1; io.q2_in = q2; io.v1_in = v1; io.v2_in = v2;
        io.alu_op_in = op; io.sign_in = sg; io.rob_tag_in = tag;
        cyc();
        io.enable = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; io.enable = 1'b0; io.q1_in = '0; io.q2_in = '0; io.v1_in = '0; io.v2_in = '0;
        io.alu_op_in = '0; io.sign_in = 1'b0; io.rob_tag_in = '0; io.cdb_valid = 1'b0; io.cdb_permit = 1'b0;
        tb_drv = 1'b0; tb_tag = '0; tb_dat = '0;
        #2 reset = 1'b0;
        @(negedge clk);
        checks++; if (io.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", io.busy); end
        checks++; if (io.buf_not_empty !== 1'b0) begin failures++; $display("FAIL rst_nonempty got=%0h exp=0", io.buf_not_empty); end
        checks++; if (io.ready_to_execute !== 1'b0 || io.fu_accept !== 1'b0 || io.buf_full !== 1'b0) begin
            failures++; $display("FAIL rst_flags got=%0h%0h%0h exp=000", io.ready_to_execute, io.fu_accept, io.buf_full); end
        // With permit on an empty slice, another producer's value must arrive unaltered.
        io.cdb_permit = 1'b1; tb_drv = 1'b1; tb_tag = 32'h0000_5A5A; tb_dat = 32'hC3C3_C3C3;
        #1;
        checks++; if (cdb_data !== 32'hC3C3_C3C3 || cdb_rob_tag !== 32'h0000_5A5A) begin
            failures++; $display("FAIL rst_cdb_release got=%0h/%0h exp=c3c3c3c3/5a5a", cdb_data, cdb_rob_tag); end
        tb_drv = 1'b0; io.cdb_permit = 1'b0;
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_capture;
        issue(32'd10, 32'd12, 32'hDEAD, 32'hBEEF, 3'b000, 1'b0, 32'd19);
        checks++; if (io.busy !== 1'b1 || io.ready_to_execute !== 1'b0 || io.fu_accept !== 1'b0) begin
            failures++; $display("FAIL cap_issue got=%0h%0h%0h exp=100", io.busy, io.ready_to_execute, io.fu_accept); end
        tb_drv = 1'b1; tb_tag = 32'd10; tb_dat = 32'd24; io.cdb_valid = 1'b1;
        cyc();
        checks++; if (io.ready_to_execute !== 1'b0) begin failures++; $display("FAIL cap_half_ready got=%0h exp=0", io.ready_to_execute); end
        tb_tag = 32'd12; tb_dat = 32'd17;
        cyc();
        tb_drv = 1'b0; io.cdb_valid = 1'b0;
        checks++; if (io.ready_to_execute !== 1'b1 || io.fu_accept !== 1'b1) begin
            failures++; $display("FAIL cap_ready got=%0h%0h exp=11", io.ready_to_execute, io.fu_accept); end
        cyc();
        checks++; if (io.ready_to_execute !== 1'b0 || io.buf_not_empty !== 1'b1 || io.busy !== 1'b1) begin
            failures++; $display("FAIL cap_dispatched got=%0h%0h%0h exp=011", io.ready_to_execute, io.buf_not_empty, io.busy); end
        io.cdb_permit = 1'b1; io.cdb_valid = 1'b1;
        #1;
        checks++; if (cdb_data !== 32'd41 || cdb_rob_tag !== 32'd19) begin
            failures++; $display("FAIL cap_cdb got=%0d/%0d exp=41/19", cdb_data, cdb_rob_tag); end
        cyc();
        io.cdb_permit = 1'b0; io.cdb_valid = 1'b0;
        checks++; if (io.busy !== 1'b0 || io.buf_not_empty !== 1'b0 || io.ready_to_execute !== 1'b0) begin
            failures++; $display("FAIL cap_freed got=%0h%0h%0h exp=000", io.busy, io.buf_not_empty, io.ready_to_execute); end
    endtask

    task automatic test_alu;
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  op;
            logic        sg;
            logic [31:0] a, b, exp;
            case (i)
                0: begin op = 3'd0; sg = 1'b1; a = 32'hFFFF_FFF0; b = 32'd4; exp = 32'hFFFF_FFEC; end
                1: begin op = 3'd5; sg = 1'b1; a = 32'hFFFF_FFF0; b = 32'd4; exp = 32'hFFFF_FFFF; end
                2: begin op = 3'd5; sg = 1'b0; a = 32'hFFFF_FFF0; b = 32'd4; exp = 32'h0FFF_FFFF; end
                3: begin op = 3'd2; sg = 1'b0; a = 32'hFFFF_FFF0; b = 32'd4; exp = 32'd1; end
                4: begin op = 3'd3; sg = 1'b0; a = 32'hFFFF_FFF0; b = 32'd4; exp = 32'd0; end
                5: begin op = 3'd0; sg = 1'b0; a = 32'hFFFF_FFFF; b = 32'd2; exp = 32'd1; end
                default: begin
                    op = 3'($urandom_range(0, 7)); sg = 1'($urandom_range(0, 1));
                    a = $urandom; b = $urandom;
                    if (i % 3 == 0) b = b & 32'h1F;
                    if (i % 5 == 0) b = a;
                    exp = ref_alu(op, sg, a, b);
                end
            endcase
            issue(32'd0, 32'd0, a, b, op, sg, 32'(100 + i));
            checks++; if (io.fu_accept !== 1'b1) begin failures++; $display("FAIL alu_accept[%0d] got=%0h exp=1", i, io.fu_accept); end
            cyc();
            io.cdb_permit = 1'b1; io.cdb_valid = 1'b1;
            #1;
            checks++; if (cdb_data !== exp || cdb_rob_tag !== 32'(100 + i)) begin
                failures++; $display("FAIL alu_result[%0d] op=%0d sign=%0d a=%h b=%h got=%h/%0d exp=%h/%0d",
                                     i, op, sg, a, b, cdb_data, cdb_rob_tag, exp, 100 + i); end
            cyc();
            io.cdb_permit = 1'b0; io.cdb_valid = 1'b0;
            checks++; if (io.busy !== 1'b0 || io.buf_not_empty !== 1'b0) begin
                failures++; $display("FAIL alu_free[%0d] got=%0h%0h exp=00", i, io.busy, io.buf_not_empty); end
        end
    endtask

    task automatic test_full_backpressure;
        logic [31:0] a, b;
        exp_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            a = $urandom; b = $urandom;
            issue(32'd0, 32'd0, a, b, 3'd4, 1'b0, 32'(200 + k));
            cyc();
            exp_q.push_back('{tag: 32'(200 + k), data: a ^ b});
            // Another producer broadcasts this ROB tag, releasing the RS without popping the FIFO.
            tb_drv = 1'b1; tb_tag = 32'(200 + k); tb_dat = '0; io.cdb_valid = 1'b1;
            cyc();
            tb_drv = 1'b0; io.cdb_valid = 1'b0;
        end
        checks++; if (io.buf_full !== 1'b1 || io.buf_not_empty !== 1'b1 || io.busy !== 1'b0) begin
            failures++; $display("FAIL full_flags got=%0h%0h%0h exp=110", io.buf_full, io.buf_not_empty, io.busy); end
        a = $urandom; b = $urandom;
        issue(32'd0, 32'd0, a, b, 3'd6, 1'b0, 32'd300);
        cyc();
        checks++; if (io.ready_to_execute !== 1'b1 || io.fu_accept !== 1'b0) begin
            failures++; $display("FAIL full_block got=%0h%0h exp=10", io.ready_to_execute, io.fu_accept); end
        io.cdb_permit = 1'b1; io.cdb_valid = 1'b1;
        #1;
        checks++; if (cdb_rob_tag !== exp_q[0].tag || cdb_data !== exp_q[0].data) begin
            failures++; $display("FAIL full_head got=%0d/%h exp=%0d/%h", cdb_rob_tag, cdb_data, exp_q[0].tag, exp_q[0].data); end
        cyc();
        void'(exp_q.pop_front());
        checks++; if (io.buf_full !== 1'b0 || io.fu_accept !== 1'b1) begin
            failures++; $display("FAIL full_unblock got=%0h%0h exp=01", io.buf_full, io.fu_accept); end
        #1;
        checks++; if (cdb_rob_tag !== exp_q[0].tag || cdb_data !== exp_q[0].data) begin
            failures++; $display("FAIL pushpop_head got=%0d/%h exp=%0d/%h", cdb_rob_tag, cdb_data, exp_q[0].tag, exp_q[0].data); end
        cyc();
        void'(exp_q.pop_front());
        exp_q.push_back('{tag: 32'd300, data: a | b});
        checks++; if (io.ready_to_execute !== 1'b0 || io.buf_full !== 1'b0) begin
            failures++; $display("FAIL pushpop_flags got=%0h%0h exp=00", io.ready_to_execute, io.buf_full); end
        for (int n = 0; n < 2 * DEPTH && exp_q.size() > 0; n++) begin
            #1;
            checks++; if (cdb_rob_tag !== exp_q[0].tag || cdb_data !== exp_q[0].data) begin
                failures++; $display("FAIL drain[%0d] got=%0d/%h exp=%0d/%h", n, cdb_rob_tag, cdb_data, exp_q[0].tag, exp_q[0].data); end
            cyc();
            void'(exp_q.pop_front());
        end
        io.cdb_permit = 1'b0; io.cdb_valid = 1'b0;
        checks++; if (exp_q.size() != 0 || io.buf_not_empty !== 1'b0 || io.busy !== 1'b0) begin
            failures++; $display("FAIL drain_end left=%0d got=%0h%0h exp=00", exp_q.size(), io.buf_not_empty, io.busy); end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            issue(32'd0, 32'd0, 32'(k + 3), 32'd5, 3'd0, 1'b0, 32'(400 + k));
            cyc();
            tb_drv = 1'b1; tb_tag = 32'(400 + k); tb_dat = '0; io.cdb_valid = 1'b1;
            cyc();
            tb_drv = 1'b0; io.cdb_valid = 1'b0;
        end
        issue(32'd77, 32'd0, 32'd0, 32'd9, 3'd0, 1'b0, 32'd410);
        checks++; if (io.busy !== 1'b1 || io.buf_not_empty !== 1'b1) begin
            failures++; $display("FAIL mid_loaded got=%0h%0h exp=11", io.busy, io.buf_not_empty); end
        reset = 1'b0;
        #1;
        checks++; if (io.busy !== 1'b0 || io.buf_not_empty !== 1'b0 || io.ready_to_execute !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%0h%0h%0h exp=000", io.busy, io.buf_not_empty, io.ready_to_execute); end
        cyc();
        reset = 1'b1;
        cyc();
        io.cdb_permit = 1'b1; io.cdb_valid = 1'b1; tb_drv = 1'b1; tb_tag = 32'd77; tb_dat = 32'h1234_5678;
        #1;
        checks++; if (cdb_data !== 32'h1234_5678 || cdb_rob_tag !== 32'd77) begin
            failures++; $display("FAIL mid_cdb_release got=%h/%0d exp=12345678/77", cdb_data, cdb_rob_tag); end
        cyc();
        io.cdb_permit = 1'b0; io.cdb_valid = 1'b0; tb_drv = 1'b0;
        checks++; if (io.busy !== 1'b0 || io.ready_to_execute !== 1'b0 || io.buf_not_empty !== 1'b0) begin
            failures++; $display("FAIL mid_after got=%0h%0h%0h exp=000", io.busy, io.ready_to_execute, io.buf_not_empty); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_alu();
        test_full_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
